// File: rtl/game_phase_timer_pkg.sv
// Shared types and helpers for the game phase sequencer: phase encodings and
// the power-up window compare.
package game_timer_pkg;

  localparam int PHASE_W    = 3;
  localparam int NUM_PHASES = 5;

  typedef enum logic [PHASE_W-1:0] {
    PH_LOGO   = 3'd0,
    PH_SELECT = 3'd1,
    PH_PLAY   = 3'd2,
    PH_SCORE  = 3'd3,
    PH_AGAIN  = 3'd4
  } phase_e;

  // Operands arrive zero-extended to 32 bits; the lower bound is formed one bit
  // wider and signed so start < len yields a negative bound instead of wrapping.
  function automatic logic in_window(input logic [31:0] secs,
                                     input logic [31:0] start,
                                     input logic [31:0] len);
    logic signed [32:0] lo;
    lo = $signed({1'b0, start}) - $signed({1'b0, len});
    return (len != 32'd0) && (secs <= start) && ($signed({1'b0, secs}) > lo);
  endfunction

endpackage

// File: rtl/game_phase_timer_if.sv
// Control inputs and phase/timer status outputs of the game phase timer.
interface game_phase_timer_if #(
  parameter int SEC_W  = 8,
  parameter int NUM_PU = 2
);
  // No handshake: every control is a level sampled on each rising clock edge,
  // and every status output is registered and valid for the whole cycle.
  logic              mode_selected;
  logic              two_player_mode;
  logic              end_game_early;
  logic              end_tutorial;
  logic              pause;
  logic              restart;
  logic [2:0]        phase;
  logic              logo;
  logic              select_mode_screen;
  logic              in_game;
  logic              end_of_game;
  logic              play_again;
  logic [SEC_W-1:0]  secs_left;
  logic              sec_pulse;
  logic [NUM_PU-1:0] powerup_on;

  modport master (
    output mode_selected, two_player_mode, end_game_early, end_tutorial, pause, restart,
    input  phase, logo, select_mode_screen, in_game, end_of_game, play_again,
    input  secs_left, sec_pulse, powerup_on
  );

  modport slave (
    input  mode_selected, two_player_mode, end_game_early, end_tutorial, pause, restart,
    output phase, logo, select_mode_screen, in_game, end_of_game, play_again,
    output secs_left, sec_pulse, powerup_on
  );
endinterface

// File: rtl/game_phase_timer_sec_prescaler.sv
// Clock-cycle prescaler: flags the cycle in which one game second completes.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic sec_pulse
);
  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // sec_pulse is combinational so the phase FSM can act on the same edge as the wrap.
  always_comb begin
    sec_pulse = enable && (cnt_q == LAST);
    cnt_d     = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = sec_pulse ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/game_phase_timer.sv
// Game phase sequencer: logo, mode select, timed play, score, play-again, with a
// seconds countdown and per-channel power-up windows during play.
module game_phase_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_W         = 8,
  parameter int LOGO_SECS     = 5,
  parameter int GAME_SECS     = 60,
  parameter int SCORE_SECS    = 4,
  parameter int NUM_PU        = 2,
  parameter logic [NUM_PU*SEC_W-1:0] PU_START = {8'd20, 8'd40},
  parameter logic [NUM_PU*SEC_W-1:0] PU_LEN   = {8'd10, 8'd5}
) (
  input logic            clock,
  input logic            reset_n,
  game_phase_timer_if.slave bus
);
  phase_e                  state_q, state_d;
  logic [NUM_PHASES-1:0]   decode_q, decode_d;
  logic [SEC_W-1:0]        secs_left_q, secs_left_d;
  logic [SEC_W-1:0]        phase_secs_q, phase_secs_d;
  logic                    sec_pulse_q, sec_pulse_d;
  logic [NUM_PU-1:0]       pu_q, pu_d;
  logic                    tick, timed, state_entry;

  assign timed = (state_q == PH_LOGO) || (state_q == PH_SCORE) ||
                 ((state_q == PH_PLAY) && !bus.pause);

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (timed),
    .clear     (state_entry),
    .sec_pulse (tick)
  );

  always_comb begin
    state_d      = state_q;
    secs_left_d  = secs_left_q;
    phase_secs_d = tick ? phase_secs_q + SEC_W'(1) : phase_secs_q;
    unique case (state_q)
      PH_LOGO:   if (tick && phase_secs_q == SEC_W'(LOGO_SECS - 1)) state_d = PH_SELECT;
      PH_SELECT: if (bus.mode_selected || bus.two_player_mode) begin
                   state_d     = PH_PLAY;
                   secs_left_d = SEC_W'(GAME_SECS);
                 end
      PH_PLAY: begin
        if (tick && secs_left_q != '0) secs_left_d = secs_left_q - SEC_W'(1);
        if (bus.end_game_early || (tick && secs_left_q == SEC_W'(1))) state_d = PH_SCORE;
      end
      PH_SCORE:  if (tick && phase_secs_q == SEC_W'(SCORE_SECS - 1)) state_d = PH_AGAIN;
      PH_AGAIN:  if (bus.restart) begin
                   state_d     = PH_SELECT;
                   secs_left_d = '0;
                 end
      default:   state_d = PH_LOGO;
    endcase
    // The tutorial skip overrides everything, including the countdown load/decrement.
    if (bus.end_tutorial && state_q != PH_AGAIN) begin
      state_d     = PH_AGAIN;
      secs_left_d = secs_left_q;
    end
    state_entry = (state_d != state_q);
    if (state_entry) phase_secs_d = '0;
    decode_d    = NUM_PHASES'(1) << state_d;
    sec_pulse_d = tick;
  end

  for (genvar i = 0; i < NUM_PU; i++) begin : g_pu
    assign pu_d[i] = (state_d == PH_PLAY) &&
                     in_window(32'(secs_left_d),
                               32'(PU_START[i*SEC_W +: SEC_W]),
                               32'(PU_LEN[i*SEC_W +: SEC_W]));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PH_LOGO;
      decode_q     <= NUM_PHASES'(1);
      secs_left_q  <= '0;
      phase_secs_q <= '0;
      sec_pulse_q  <= 1'b0;
      pu_q         <= '0;
    end else begin
      state_q      <= state_d;
      decode_q     <= decode_d;
      secs_left_q  <= secs_left_d;
      phase_secs_q <= phase_secs_d;
      sec_pulse_q  <= sec_pulse_d;
      pu_q         <= pu_d;
    end
  end

  assign bus.phase              = state_q;
  assign bus.logo               = decode_q[PH_LOGO];
  assign bus.select_mode_screen = decode_q[PH_SELECT];
  assign bus.in_game            = decode_q[PH_PLAY];
  assign bus.end_of_game        = decode_q[PH_SCORE];
  assign bus.play_again         = decode_q[PH_AGAIN];
  assign bus.secs_left          = secs_left_q;
  assign bus.sec_pulse          = sec_pulse_q;
  assign bus.powerup_on         = pu_q;
endmodule

// File: tb/tb_game_phase_timer.sv
// Bench for game_phase_timer: directed vector table, async reset and tutorial
// sequences, then random controls checked every cycle against a reference model.
module tb_game_phase_timer;
  localparam int TPS = 4, SEC_W = 8, LOGO_S = 2, GAME_S = 5, SCORE_S = 2, NUM_PU = 2;
  localparam int OUT_W = 3 + 5 + SEC_W + 1 + NUM_PU;
  localparam int M_LOGO = 0, M_SELECT = 1, M_PLAY = 2, M_SCORE = 3, M_AGAIN = 4;
  localparam logic [OUT_W-1:0] RESET_VEC = {3'd0, 5'b00001, 8'd0, 1'b0, 2'b00};

  typedef struct {
    logic [5:0] ctrl;   // {restart, pause, end_tutorial, end_game_early, two_player, mode_selected}
    int         cycles;
    logic [2:0] ph;
    logic [7:0] secs;
    logic [1:0] pu;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  vec_t vecs[25];

  int   pu_start[NUM_PU] = '{4, 2};
  int   pu_len[NUM_PU]   = '{1, 2};
  int   m_ph, m_active, m_left;
  logic m_pulse;

  // clock / reset
  always #5 clock = ~clock;

  game_phase_timer_if #(.SEC_W(SEC_W), .NUM_PU(NUM_PU)) bus ();

  game_phase_timer #(
    .TICKS_PER_SEC(TPS), .SEC_W(SEC_W), .LOGO_SECS(LOGO_S), .GAME_SECS(GAME_S),
    .SCORE_SECS(SCORE_S), .NUM_PU(NUM_PU),
    .PU_START({8'd2, 8'd4}), .PU_LEN({8'd2, 8'd1})
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // reference model: time spent in the current phase, seconds derived by division
  function automatic logic [NUM_PU-1:0] model_pu(int ph, int left);
    logic [NUM_PU-1:0] r;
    for (int i = 0; i < NUM_PU; i++)
      r[i] = (ph == M_PLAY) && (pu_len[i] != 0) && (left <= pu_start[i]) &&
             (left > pu_start[i] - pu_len[i]);
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] model_vec();
    return {3'(m_ph), 5'(1 << m_ph), 8'(m_left), m_pulse, model_pu(m_ph, m_left)};
  endfunction

  task automatic model_reset();
    m_ph = M_LOGO; m_active = 0; m_left = 0; m_pulse = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int   nxt, act, left;
    logic timed;
    timed   = (m_ph == M_LOGO) || (m_ph == M_SCORE) || (m_ph == M_PLAY && !bus.pause);
    m_pulse = timed && ((m_active + 1) % TPS == 0);
    act     = m_active + (timed ? 1 : 0);
    nxt     = m_ph;
    left    = m_left;
    case (m_ph)
      M_LOGO:   if (act == LOGO_S * TPS) nxt = M_SELECT;
      M_SELECT: if (bus.mode_selected || bus.two_player_mode) begin nxt = M_PLAY; left = GAME_S; end
      M_PLAY: begin
        left = GAME_S - act / TPS;
        if (left < 0) left = 0;
        if (bus.end_game_early || left == 0) nxt = M_SCORE;
      end
      M_SCORE:  if (act == SCORE_S * TPS) nxt = M_AGAIN;
      M_AGAIN:  if (bus.restart) begin nxt = M_SELECT; left = 0; end
      default:  nxt = M_LOGO;
    endcase
    if (bus.end_tutorial && m_ph != M_AGAIN) begin nxt = M_AGAIN; left = m_left; end
    m_active = (nxt != m_ph) ? 0 : act;
    m_ph     = nxt;
    m_left   = left;
  endtask

  // driver tasks
  task automatic apply(input logic [5:0] c);
    bus.mode_selected   = c[0];
    bus.two_player_mode = c[1];
    bus.end_game_early  = c[2];
    bus.end_tutorial    = c[3];
    bus.pause           = c[4];
    bus.restart         = c[5];
  endtask

  function automatic logic [OUT_W-1:0] dut_vec();
    return {bus.phase, bus.play_again, bus.end_of_game, bus.in_game, bus.select_mode_screen,
            bus.logo, bus.secs_left, bus.sec_pulse, bus.powerup_on};
  endfunction

  // scoreboard
  task automatic check_out(input string name, input logic [OUT_W-1:0] act,
                           input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    exp_q.push_back(model_vec());
    @(negedge clock);
    check_out("cycle", dut_vec(), exp_q.pop_front());
  endtask

  task automatic run_vec(input vec_t v, input string name);
    apply(v.ctrl);
    repeat (v.cycles) step();
    n_checks++;
    if ({bus.phase, bus.secs_left, bus.powerup_on} !== {v.ph, v.secs, v.pu}) begin
      n_err++;
      $display("FAIL %s: got phase=%0d secs=%0d pu=%b expected phase=%0d secs=%0d pu=%b",
               name, bus.phase, bus.secs_left, bus.powerup_on, v.ph, v.secs, v.pu);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] c, input int n, input logic [2:0] ph,
                              input logic [7:0] s, input logic [1:0] pu);
    vec_t v;
    v.ctrl = c; v.cycles = n; v.ph = ph; v.secs = s; v.pu = pu;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(6'h00,  7, 3'd0, 8'd0, 2'b00);  // still in logo
    vecs[1]  = mk(6'h00,  1, 3'd1, 8'd0, 2'b00);  // logo ends after 8 cycles
    vecs[2]  = mk(6'h00, 10, 3'd1, 8'd0, 2'b00);  // select holds
    vecs[3]  = mk(6'h01,  1, 3'd2, 8'd5, 2'b00);
    vecs[4]  = mk(6'h00,  4, 3'd2, 8'd4, 2'b01);
    vecs[5]  = mk(6'h00,  4, 3'd2, 8'd3, 2'b00);
    vecs[6]  = mk(6'h10, 10, 3'd2, 8'd3, 2'b00);  // paused
    vecs[7]  = mk(6'h00,  3, 3'd2, 8'd3, 2'b00);
    vecs[8]  = mk(6'h00,  1, 3'd2, 8'd2, 2'b10);
    vecs[9]  = mk(6'h00,  4, 3'd2, 8'd1, 2'b10);
    vecs[10] = mk(6'h00,  3, 3'd2, 8'd1, 2'b10);
    vecs[11] = mk(6'h00,  1, 3'd3, 8'd0, 2'b00);  // 30 cycles of play
    vecs[12] = mk(6'h00,  7, 3'd3, 8'd0, 2'b00);
    vecs[13] = mk(6'h00,  1, 3'd4, 8'd0, 2'b00);
    vecs[14] = mk(6'h00,  5, 3'd4, 8'd0, 2'b00);
    vecs[15] = mk(6'h20,  1, 3'd1, 8'd0, 2'b00);
    vecs[16] = mk(6'h02,  1, 3'd2, 8'd5, 2'b00);
    vecs[17] = mk(6'h00,  4, 3'd2, 8'd4, 2'b01);
    vecs[18] = mk(6'h04,  1, 3'd3, 8'd4, 2'b00);  // early end
    vecs[19] = mk(6'h00,  8, 3'd4, 8'd4, 2'b00);
    vecs[20] = mk(6'h20,  1, 3'd1, 8'd0, 2'b00);
    vecs[21] = mk(6'h08,  1, 3'd4, 8'd0, 2'b00);  // tutorial skip from select
    vecs[22] = mk(6'h20,  1, 3'd1, 8'd0, 2'b00);
    vecs[23] = mk(6'h01,  1, 3'd2, 8'd5, 2'b00);
    vecs[24] = mk(6'h00,  6, 3'd2, 8'd4, 2'b01);

    apply(6'h00);
    model_reset();
    repeat (2) @(negedge clock);
    check_out("reset_values", dut_vec(), RESET_VEC);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of play
    #2 reset_n = 1'b0;
    #1 check_out("async_reset", dut_vec(), RESET_VEC);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    run_vec(mk(6'h00, 7, 3'd0, 8'd0, 2'b00), "relogo_hold");
    run_vec(mk(6'h00, 1, 3'd1, 8'd0, 2'b00), "relogo_end");

    // tutorial skip out of play keeps the countdown value
    run_vec(mk(6'h01, 1, 3'd2, 8'd5, 2'b00), "play_entry");
    run_vec(mk(6'h08, 1, 3'd4, 8'd5, 2'b00), "tutorial_from_play");
    run_vec(mk(6'h20, 1, 3'd1, 8'd0, 2'b00), "restart_clears");

    // random controls against the model
    apply(6'h00);
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] c;
      c[0] = ($urandom_range(0, 9) == 0);
      c[1] = ($urandom_range(0, 19) == 0);
      c[2] = ($urandom_range(0, 39) == 0);
      c[3] = ($urandom_range(0, 79) == 0);
      c[4] = ($urandom_range(0, 9) == 0) ? ~bus.pause : bus.pause;
      c[5] = ($urandom_range(0, 9) == 0);
      apply(c);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/game_phase_timer.md
# game_phase_timer

Parametrised phase sequencer and countdown timer for the game top level. It steps through logo, mode-select, timed play, score display and play-again phases. While the game is running it drives a seconds countdown and a configurable number of timed power-up windows. Durations, clock rate, counter width and power-up channel count are parameters, so the same block serves single-player, two-player and tutorial builds.

## Interface
- TICKS_PER_SEC, 50_000_000: clock cycles per game second; must be ≥2.
- SEC_W, 8: width of all seconds quantities.
- LOGO_SECS, 5: logo phase length in seconds; must be ≥1.
- GAME_SECS, 60: play phase length in seconds; must be ≥1 and < 2^SEC_W.
- SCORE_SECS, 4: score phase length before play-again is offered; must be ≥1.
- NUM_PU, 2: number of power-up channels.
- PU_START, packed NUM_PU×SEC_W: per channel, the secs_left value at which the window opens.
- PU_LEN, packed NUM_PU×SEC_W: per channel, window length in seconds; 0 disables the channel.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode_selected  in  1  player chose a mode on the select screen.
- two_player_mode  in  1  two-player start; equivalent to mode_selected.
- end_game_early  in  1  abort play and go to score.
- end_tutorial  in  1  skip directly to play-again.
- pause  in  1  level; freezes play-phase timing.
- restart  in  1  in AGAIN, return to SELECT.
- phase  out  3  current state encoding.
- logo, select_mode_screen, in_game, end_of_game, play_again  out  1 each  one-hot phase decodes.
- secs_left  out  SEC_W  remaining play seconds.
- sec_pulse  out  1  one-cycle pulse per elapsed timed second.
- powerup_on  out  NUM_PU  per-channel power-up window active.

## Operation
- States: LOGO=0, SELECT=1, PLAY=2, SCORE=3, AGAIN=4. Reset enters LOGO.
- Decodes: logo=LOGO, select_mode_screen=SELECT, in_game=PLAY, end_of_game=SCORE, play_again=AGAIN.
- Prescaler:
  - counts 0..TICKS_PER_SEC-1 only in LOGO, SCORE, and PLAY with pause=0;
  - cleared to 0 on every state entry;
  - holds its value in SELECT, AGAIN, and PLAY while pause=1;
  - sec_pulse=1 for the cycle in which the prescaler wraps from TICKS_PER_SEC-1 to 0.
- A phase-seconds counter increments on each sec_pulse and is cleared on state entry.
- LOGO→SELECT on the sec_pulse that completes LOGO_SECS seconds.
- SELECT→PLAY when mode_selected|two_player_mode. On entry, secs_left loads GAME_SECS.
- PLAY:
  - each sec_pulse decrements secs_left;
  - the pulse that takes secs_left from 1 to 0 moves the block to SCORE;
  - end_game_early moves the block to SCORE immediately;
  - if both occur in the same cycle, the block takes a single transition to SCORE;
  - secs_left never wraps below 0.
- SCORE→AGAIN after SCORE_SECS seconds. end_tutorial in any state other than AGAIN also jumps to AGAIN and has priority over all other transitions.
- AGAIN→SELECT on restart. secs_left resets to 0 on this transition.
- powerup_on[i] is registered and is 1 iff:
  - state is PLAY;
  - PU_LEN[i]≠0;
  - secs_left ≤ PU_START[i] and secs_left > PU_START[i]−PU_LEN[i], with the subtraction done at SEC_W+1 bits, signed-safe.
- Pause does not clear powerup_on.

## Timing
- Reset values:
  - phase=LOGO, logo=1, all other decodes 0;
  - secs_left=0, sec_pulse=0, powerup_on=0;
  - prescaler and phase-seconds counter 0.
- All outputs are registered. A transition caused by an input sampled at edge n is visible after edge n.
- LOGO lasts exactly LOGO_SECS×TICKS_PER_SEC cycles after reset release. SCORE lasts exactly SCORE_SECS×TICKS_PER_SEC cycles.
- An unpaused PLAY lasts exactly GAME_SECS×TICKS_PER_SEC cycles.
- powerup_on updates in the same cycle that secs_left changes.
- Asserting reset_n low mid-game forces reset values at once. Timing restarts from LOGO on release.

## Structure
- Shared package game_timer_pkg:
  - phase_e enum with the encodings above;
  - helper function in_window(secs, start, len).
- Sub-module sec_prescaler, parameter TICKS_PER_SEC. Ports: clock, reset_n, enable, clear; outputs sec_pulse.
- FSM, seconds counters and power-up compare live in game_phase_timer. The power-up compare is a generate loop over NUM_PU.

## Test plan
All scenarios use TICKS_PER_SEC=4, LOGO_SECS=2, GAME_SECS=5, SCORE_SECS=2, NUM_PU=2, PU_START={ch1=2, ch0=4}, PU_LEN={ch1=2, ch0=1}.
- Release reset, hold inputs low → logo=1 for 8 cycles, then select_mode_screen=1, which holds indefinitely.
- In SELECT, pulse mode_selected → in_game=1 and secs_left=5. secs_left counts 5,4,3,2,1,0 at 4-cycle spacing. end_of_game rises when 0 is reached, 20 cycles after entry. play_again follows 8 cycles later.
- During PLAY → powerup_on[0]=1 only while secs_left=4; powerup_on[1]=1 while secs_left=2 and 1; both are 0 in SCORE.
- Hold pause for 10 cycles at secs_left=3 → secs_left and prescaler freeze and sec_pulse=0. Total PLAY duration becomes 30 cycles.
- Scenario 5:
  - assert end_game_early at secs_left=4 → SCORE next cycle;
  - assert end_tutorial in SELECT → AGAIN next cycle;
  - assert restart → SELECT with secs_left=0.
- Drop reset_n mid-PLAY → all outputs return to reset values asynchronously, and the logo sequence repeats after release.
